// File: rtl/key_search_sequencer_pkg.sv
// ============================================================================
// Module      : key_search_sequencer_pkg
// Description : Mode codes, sequencer state type and key-width defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_search_sequencer_pkg;

   localparam logic [5:0] MODE_IDLE = 6'b000_000;
   localparam logic [5:0] MODE_INIT = 6'b001_000;
   localparam logic [5:0] MODE_SHUF = 6'b010_000;
   localparam logic [5:0] MODE_DECR = 6'b011_000;

   localparam int DEF_RAM_WIDTH  = 8;
   localparam int DEF_KEY_LENGTH = 3;
   localparam int DEF_KEY_BITS   = 22;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_INIT      = 4'd1,
      ST_GAP1      = 4'd2,
      ST_SHUF      = 4'd3,
      ST_GAP2      = 4'd4,
      ST_DECR      = 4'd5,
      ST_CHECK     = 4'd6,
      ST_FOUND     = 4'd7,
      ST_EXHAUSTED = 4'd8,
      ST_ERROR     = 4'd9
   } seq_state_t;

   function automatic logic [5:0] mode_of(seq_state_t s);
      logic [5:0] m;
      case (s)
         ST_INIT: m = MODE_INIT;
         ST_SHUF: m = MODE_SHUF;
         ST_DECR: m = MODE_DECR;
         default: m = MODE_IDLE;
      endcase
      return m;
   endfunction

   function automatic logic in_phase(seq_state_t s);
      return (s == ST_INIT) || (s == ST_SHUF) || (s == ST_DECR);
   endfunction

   // Busy covers the phases plus the gap and check cycles between them.
   function automatic logic in_search(seq_state_t s);
      return (s == ST_INIT) || (s == ST_GAP1) || (s == ST_SHUF) ||
             (s == ST_GAP2) || (s == ST_DECR) || (s == ST_CHECK);
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_search_sequencer_if.sv
// ============================================================================
// Module      : key_search_sequencer_if
// Description : Control / RAM-controller signal bundle around the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_search_sequencer_if
   import key_search_sequencer_pkg::*;
#(
   parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
   parameter int KEY_LENGTH = DEF_KEY_LENGTH
);
   logic                                 start;
   logic                                 abort;
   logic [2:0]                           finish_bus;
   logic                                 success;
   logic [5:0]                           mode;
   logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key;
   logic                                 busy;
   logic                                 found;
   logic                                 exhausted;
   logic                                 wdog_err;

   modport master (
      input  start, abort, finish_bus, success,
      output mode, key, busy, found, exhausted, wdog_err
   );

   modport slave (
      output start, abort, finish_bus, success,
      input  mode, key, busy, found, exhausted, wdog_err
   );
endinterface

`default_nettype wire

// File: rtl/key_search_sequencer_phase_watchdog.sv
// ============================================================================
// Module      : phase_watchdog
// Description : Per-phase cycle budget counter; expired flags the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_watchdog
   import key_search_sequencer_pkg::*;
#(
   parameter int WDOG_CYCLES = 4096
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic clear,
   input  wire logic enable,
   output logic      expired
);
   localparam int               CNT_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   // High during the WDOG_CYCLES-th cycle of the phase.
   assign expired = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/key_search_sequencer.sv
// ============================================================================
// Module      : key_search_sequencer
// Description : Walks the key space running init->shuffle->decrypt per key.
//               SEQ_WATCHDOG_EN adds a per-phase timeout and ERROR state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_search_sequencer
   import key_search_sequencer_pkg::*;
#(
   parameter int                  RAM_WIDTH   = DEF_RAM_WIDTH,
   parameter int                  KEY_LENGTH  = DEF_KEY_LENGTH,
   parameter int                  KEY_BITS    = DEF_KEY_BITS,
   parameter logic [KEY_BITS-1:0] KEY_FIRST   = '0,
   parameter logic [KEY_BITS-1:0] KEY_LAST    = '1,
   parameter int                  WDOG_CYCLES = 4096
) (
   input  wire logic              clk,
   input  wire logic              reset,
   key_search_sequencer_if.master bus
);
   localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;

   seq_state_t          state;
   seq_state_t          state_nxt;
   logic [KEY_BITS-1:0] key_cnt;
   logic [KEY_BITS-1:0] key_cnt_nxt;
   logic [5:0]          mode_q;
   logic                busy_q;
   logic                found_q;
   logic                found_nxt;
   logic                exh_q;
   logic                exh_nxt;
   logic                verdict_q;
   logic                verdict_nxt;
   logic                restart;
   logic                timeout;
   logic [KEY_W-1:0]    key_flat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         key_cnt   <= KEY_FIRST;
         mode_q    <= MODE_IDLE;
         busy_q    <= 1'b0;
         found_q   <= 1'b0;
         exh_q     <= 1'b0;
         verdict_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         key_cnt   <= key_cnt_nxt;
         mode_q    <= mode_of(state_nxt);
         busy_q    <= in_search(state_nxt);
         found_q   <= found_nxt;
         exh_q     <= exh_nxt;
         verdict_q <= verdict_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      key_cnt_nxt = key_cnt;
      found_nxt   = found_q;
      exh_nxt     = exh_q;
      verdict_nxt = verdict_q;
      restart     = 1'b0;

      if (bus.abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
               if (bus.start) begin
                  restart     = 1'b1;
                  state_nxt   = ST_INIT;
                  key_cnt_nxt = KEY_FIRST;
                  found_nxt   = 1'b0;
                  exh_nxt     = 1'b0;
               end
            end
            ST_INIT: begin
               if (bus.finish_bus[0]) state_nxt = ST_GAP1;
               else if (timeout)      state_nxt = ST_ERROR;
            end
            ST_GAP1: state_nxt = ST_SHUF;
            ST_SHUF: begin
               if (bus.finish_bus[1]) state_nxt = ST_GAP2;
               else if (timeout)      state_nxt = ST_ERROR;
            end
            ST_GAP2: state_nxt = ST_DECR;
            ST_DECR: begin
               // The verdict is only valid alongside the decryptor's finish bit.
               if (bus.finish_bus[2]) begin
                  verdict_nxt = bus.success;
                  state_nxt   = ST_CHECK;
               end else if (timeout) begin
                  state_nxt = ST_ERROR;
               end
            end
            ST_CHECK: begin
               if (verdict_q) begin
                  state_nxt = ST_FOUND;
                  found_nxt = 1'b1;
               end else if (key_cnt == KEY_LAST) begin
                  state_nxt = ST_EXHAUSTED;
                  exh_nxt   = 1'b1;
               end else begin
                  key_cnt_nxt = key_cnt + 1'b1;
                  state_nxt   = ST_INIT;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

`ifdef SEQ_WATCHDOG_EN
   logic phase_active;
   logic wd_expired;
   logic wdog_q;

   assign phase_active = in_phase(state);

   // Every phase is entered from a non-phase state, so holding the counter
   // clear outside the phases restarts it on each entry.
   phase_watchdog #(
      .WDOG_CYCLES(WDOG_CYCLES)
   ) u_phase_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (!phase_active),
      .enable (phase_active),
      .expired(wd_expired)
   );

   assign timeout = wd_expired;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_q <= 1'b0;
      end else if (restart) begin
         wdog_q <= 1'b0;
      end else if (state_nxt == ST_ERROR) begin
         wdog_q <= 1'b1;
      end
   end

   assign bus.wdog_err = wdog_q;
`else
   assign timeout      = 1'b0;
   assign bus.wdog_err = 1'b0;
`endif

   always_comb begin
      key_flat                 = '0;
      key_flat[KEY_BITS-1:0]   = key_cnt;
   end

   assign bus.key       = key_flat;
   assign bus.mode      = mode_q;
   assign bus.busy      = busy_q;
   assign bus.found     = found_q;
   assign bus.exhausted = exh_q;

endmodule

`default_nettype wire
